// File: rtl/data_sram_resp.sv
// Single-port word SRAM behind a valid/ready request port with configurable wait states.
// Each accepted request completes with a one-cycle resp_valid pulse; reads return data in rdata.

module data_sram_lane (
  input  logic       wen,
  input  logic [7:0] wbyte,
  input  logic [7:0] old,
  output logic [7:0] merged
);
  assign merged = wen ? wbyte : old;
endmodule

module data_sram_resp #(
  parameter int DEPTH_LOG2  = 10,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        data_sram_en,
  input  logic [3:0]  data_sram_wen,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic        data_sram_ready,
  output logic [31:0] data_sram_rdata,
  output logic        resp_valid
);
  localparam int DEPTH     = 1 << DEPTH_LOG2;
  localparam int NUM_LANES = 4;
  localparam logic [2:0] CNT_INIT = 3'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  typedef struct packed {
    logic [DEPTH_LOG2-1:0] idx;
    logic [3:0]            wen;
    logic [31:0]           wdata;
  } req_t;

  state_t      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  req_t        req_q, req_d;
  logic [31:0] rdata_q, rdata_d;

  req_t  req_in, op;
  logic  accept, commit;
  logic [NUM_LANES-1:0][7:0] mem [DEPTH];
  logic [NUM_LANES-1:0][7:0] cur_word, merged;

  logic unused_addr;
  assign unused_addr = ^{data_sram_addr[31:DEPTH_LOG2+2], data_sram_addr[1:0]};

  assign req_in = '{idx:   data_sram_addr[DEPTH_LOG2+1:2],
                    wen:   data_sram_wen,
                    wdata: data_sram_wdata};

  assign data_sram_ready = (state_q == IDLE) || (state_q == RESP);
  assign accept          = data_sram_en && data_sram_ready;
  assign resp_valid      = (state_q == RESP);
  assign data_sram_rdata = rdata_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    commit  = 1'b0;
    case (state_q)
      IDLE, RESP: begin
        if (accept) begin
          req_d = req_in;
          if (WAIT_CYCLES == 0) begin
            state_d = RESP;
            commit  = 1'b1;
          end else begin
            state_d = WAIT;
            cnt_d   = CNT_INIT;
          end
        end else begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        if (cnt_q == 3'd0) begin
          state_d = RESP;
          commit  = 1'b1;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Zero-wait accesses commit straight off the port; otherwise from the latched request.
  always_comb begin
    op       = (state_q == WAIT) ? req_q : req_in;
    cur_word = mem[op.idx];
    rdata_d  = rdata_q;
    if (commit && (op.wen == 4'b0000)) rdata_d = cur_word;
  end

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    data_sram_lane u_lane (
      .wen   (op.wen[i]),
      .wbyte (op.wdata[8*i +: 8]),
      .old   (cur_word[i]),
      .merged(merged[i])
    );
  end

  // Array is never reset; a reset landing on the commit edge must still block the write.
  always_ff @(posedge clk) begin
    if (!rst && commit && (|op.wen)) mem[op.idx] <= merged;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 3'd0;
      req_q   <= '0;
      rdata_q <= 32'h0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      rdata_q <= rdata_d;
    end
  end
endmodule
